patgen_playback: RTL and testbench

- Pattern generator. The output-direction counterpart of the capture block.
- Consumes an AXI-stream of sample words from the playback FIFO, which is fed by DMA.
- Drives the words onto a parallel output bus at a programmable divided rate.
- Control and status mirror capture: arm, armed, start, abort, done, ready.

---
 rtl/patgen_playback.sv | 216 +++++++++++++++++++++
 tb/tb_patgen_playback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/patgen_playback.sv
`default_nettype none
// =============================================================================
// patgen_playback : plays an AXI-stream of sample words onto dout at ckdiv+1 rate
// Optional build macro PATGEN_UNDERRUN_HALT_EN ends the pattern on first underrun.
// Revision: 1.0
// =============================================================================
module patgen_playback #(
   parameter int SIZE    = 32,
   parameter int MAX_DIV = 32,
   parameter int SADDR_W = 24,
   localparam int DIV_W  = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SIZE-1:0]    tdata,
   input  logic               tvalid,
   output logic               tready,
   input  logic               tlast,
   input  logic [DIV_W-1:0]   ckdiv,
   input  logic [SADDR_W-1:0] sample_count,
   input  logic [SIZE-1:0]    idle_level,
   input  logic               arm,
   input  logic               start,
   input  logic               abort,
   output logic               ready,
   output logic               armed,
   output logic               running,
   output logic               done,
   output logic               underrun,
   output logic [SADDR_W-1:0] emitted,
   output logic [SIZE-1:0]    dout
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_ARMED = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   ckdiv_l_q, ckdiv_l_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [SADDR_W-1:0] count_l_q, count_l_d;
   logic [SADDR_W-1:0] emitted_q, emitted_d;
   logic [SIZE-1:0]    idle_l_q, idle_l_d;
   logic [SIZE-1:0]    hold_q, hold_d;
   logic [SIZE-1:0]    dout_q, dout_d;
   logic               hold_last_q, hold_last_d;
   logic               hold_valid_q, hold_valid_d;
   logic               fin_q, fin_d;
   logic               underrun_q, underrun_d;

   logic               gate;
   logic               tick;
   logic               take;
   logic               tready_c;
   logic               bypass;
   logic [SIZE-1:0]    emit_data;
   logic               emit_last;
   logic [SADDR_W-1:0] emitted_inc;

   always_comb begin
      state_d      = state_q;
      ckdiv_l_d    = ckdiv_l_q;
      count_l_d    = count_l_q;
      idle_l_d     = idle_l_q;
      hold_d       = hold_q;
      hold_last_d  = hold_last_q;
      hold_valid_d = hold_valid_q;
      div_d        = div_q;
      emitted_d    = emitted_q;
      underrun_d   = underrun_q;
      fin_d        = fin_q;
      dout_d       = dout_q;
      tready_c     = 1'b0;
      take         = 1'b0;
      bypass       = 1'b0;
      emit_data    = '0;
      emit_last    = 1'b0;
      gate         = !abort && !reset;
      emitted_inc  = (&emitted_q) ? emitted_q : emitted_q + 1'b1;
      tick         = (state_q == ST_RUN) && (div_q == ckdiv_l_q);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               ckdiv_l_d    = ckdiv;
               count_l_d    = sample_count;
               idle_l_d     = idle_level;
               emitted_d    = '0;
               underrun_d   = 1'b0;
               fin_d        = 1'b0;
               hold_valid_d = 1'b0;
               state_d      = ST_PRIME;
            end
         end

         ST_PRIME: begin
            tready_c = 1'b1;
            take     = tvalid && gate;
            if (take) begin
               hold_d       = tdata;
               hold_last_d  = tlast;
               hold_valid_d = 1'b1;
               state_d      = ST_ARMED;
            end
         end

         ST_ARMED: begin
            if (start) begin
               // Preloading terminal count makes the first RUN cycle a tick.
               div_d   = ckdiv_l_q;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            // A held tlast beat blocks refill so the next pattern's data stays in the stream.
`ifdef PATGEN_UNDERRUN_HALT_EN
            tready_c = !fin_q && (hold_valid_q ? (tick && !hold_last_q) : !tick);
`else
            tready_c = !fin_q && (hold_valid_q ? (tick && !hold_last_q) : 1'b1);
`endif
            take = tready_c && tvalid && gate;

            if (tick && fin_q) begin
               state_d = ST_DONE;
               dout_d  = idle_l_q;
            end else if (tick) begin
               if (!hold_valid_q) begin
                  underrun_d = 1'b1;
`ifdef PATGEN_UNDERRUN_HALT_EN
                  state_d    = ST_DONE;
                  dout_d     = idle_l_q;
`endif
               end
               // During a stretched tick a freshly arriving beat goes straight to dout.
               if (hold_valid_q || take) begin
                  bypass       = !hold_valid_q;
                  emit_data    = hold_valid_q ? hold_q : tdata;
                  emit_last    = hold_valid_q ? hold_last_q : tlast;
                  dout_d       = emit_data;
                  emitted_d    = emitted_inc;
                  div_d        = '0;
                  hold_valid_d = 1'b0;
                  fin_d        = emit_last ||
                                 ((count_l_q != '0) && (emitted_inc == count_l_q));
               end
            end else begin
               div_d = div_q + 1'b1;
            end

            if (take && !bypass) begin
               hold_d       = tdata;
               hold_last_d  = tlast;
               hold_valid_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         state_d      = ST_IDLE;
         dout_d       = idle_l_q;
         hold_valid_d = 1'b0;
         fin_d        = 1'b0;
         div_d        = '0;
         emitted_d    = emitted_q;
         underrun_d   = underrun_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ckdiv_l_q    <= '0;
         count_l_q    <= '0;
         idle_l_q     <= '0;
         hold_q       <= '0;
         hold_last_q  <= 1'b0;
         hold_valid_q <= 1'b0;
         div_q        <= '0;
         emitted_q    <= '0;
         underrun_q   <= 1'b0;
         fin_q        <= 1'b0;
         dout_q       <= '0;
      end else begin
         state_q      <= state_d;
         ckdiv_l_q    <= ckdiv_l_d;
         count_l_q    <= count_l_d;
         idle_l_q     <= idle_l_d;
         hold_q       <= hold_d;
         hold_last_q  <= hold_last_d;
         hold_valid_q <= hold_valid_d;
         div_q        <= div_d;
         emitted_q    <= emitted_d;
         underrun_q   <= underrun_d;
         fin_q        <= fin_d;
         dout_q       <= dout_d;
      end
   end

   assign tready   = tready_c && gate;
   assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign armed    = (state_q == ST_ARMED);
   assign running  = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign underrun = underrun_q;
   assign emitted  = emitted_q;
   assign dout     = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_patgen_playback.sv
`default_nettype none
// =============================================================================
// tb_patgen_playback : directed and randomized playback checks against an
// event-time model of sample emission. Revision: 1.0
// =============================================================================
module tb_patgen_playback;

`ifdef PATGEN_UNDERRUN_HALT_EN
   localparam bit HALT = 1'b1;
`else
   localparam bit HALT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic [4:0]  ckdiv;
   logic [23:0] sample_count;
   logic [31:0] idle_level;
   logic        arm, start, abort;
   logic        ready, armed, running, done, underrun;
   logic [23:0] emitted;
   logic [31:0] dout;

   int nassert = 0;
   int nfail   = 0;

   logic [31:0] sd [16];
   logic        sl [16];
   int          sr [16];
   int          nb, head, cidx, n_acc;

   always #5 clk = ~clk;

   patgen_playback dut (
      .clk(clk), .reset(reset), .tdata(tdata), .tvalid(tvalid), .tready(tready),
      .tlast(tlast), .ckdiv(ckdiv), .sample_count(sample_count),
      .idle_level(idle_level), .arm(arm), .start(start), .abort(abort),
      .ready(ready), .armed(armed), .running(running), .done(done),
      .underrun(underrun), .emitted(emitted), .dout(dout)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      if (head < nb) begin
         tvalid = (cidx >= sr[head]);
         tdata  = sd[head];
         tlast  = sl[head];
      end else begin
         tvalid = 1'b0;
         tdata  = '0;
         tlast  = 1'b0;
      end
   endtask

   task automatic cyc();
      logic acc;
      @(negedge clk);
      acc = tvalid && tready;
      @(posedge clk);
      #1;
      if (acc) begin
         head++;
         n_acc++;
      end
      cidx++;
      drive_src();
   endtask

   // Beat i (i>0) is offered from RUN cycle sr[i] onward; beat 0 is always ready.
   task automatic mk_stream(input int n_beats, input int tl_idx, input int gap_max,
                            input bit rnd, input logic [31:0] base);
      int t;
      t = 0;
      for (int i = 0; i < 16; i++) begin
         sd[i] = rnd ? $urandom : base + 32'(i);
         sl[i] = (i == tl_idx);
         if (i == 0 || gap_max == 0) begin
            sr[i] = -1000;
         end else begin
            t     = t + int'($urandom_range(0, gap_max));
            sr[i] = t;
         end
      end
      nb = n_beats;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " ready"},    64'(ready),    64'd1);
      chk({tag, " armed"},    64'(armed),    64'd0);
      chk({tag, " running"},  64'(running),  64'd0);
      chk({tag, " done"},     64'(done),     64'd0);
      chk({tag, " underrun"}, 64'(underrun), 64'd0);
      chk({tag, " emitted"},  64'(emitted),  64'd0);
      chk({tag, " dout"},     64'(dout),     64'd0);
      chk({tag, " tready"},   64'(tready),   64'd0);
   endtask

   // Emission model: sample i leaves at e[i] = max(e[i-1]+d+1, v[i]), where v[i]
   // is when beat i is first offered; v[i] >= due marks an underrun tick.
   task automatic play(input string name, input int d, input int cnt, input int n,
                       input logic [31:0] idle, input int abort_at, input int rst_at);
      int e [16];
      int v [16];
      int a [16];
      int due [16];
      int iu, tdone, nemit, exp_acc, vn, ne;
      logic [31:0] exp_dout;

      ckdiv        = 5'(d);
      sample_count = 24'(cnt);
      idle_level   = idle;
      head  = 0;
      n_acc = 0;
      cidx  = -100;
      drive_src();

      e[0] = 0;
      a[0] = -1;
      iu   = -1;
      for (int i = 1; i < n; i++) begin
         due[i] = e[i-1] + d + 1;
         v[i]   = (sr[i] > a[i-1] + 1) ? sr[i] : a[i-1] + 1;
         if (v[i] >= due[i] && iu < 0) iu = i;
         if (HALT && iu >= 0) break;
         e[i] = (due[i] > v[i]) ? due[i] : v[i];
         a[i] = (v[i] > e[i-1]) ? v[i] : e[i-1];
      end
      if (HALT && iu >= 0) begin
         nemit   = iu;
         tdone   = due[iu];
         exp_acc = iu;
      end else begin
         nemit   = n;
         tdone   = e[n-1] + d + 1;
         exp_acc = n;
         if (cnt != 0 && nb > n) begin
            vn = (sr[n] > a[n-1] + 1) ? sr[n] : a[n-1] + 1;
            if (vn <= e[n-1]) exp_acc = n + 1;
         end
      end

      arm = 1'b1;
      cyc();
      arm = 1'b0;
      chk({name, " prime ready"},    64'(ready),    64'd0);
      chk({name, " prime emitted"},  64'(emitted),  64'd0);
      chk({name, " prime underrun"}, 64'(underrun), 64'd0);
      chk({name, " prime tready"},   64'(tready),   64'd1);
      cyc();
      chk({name, " armed"},        64'(armed),  64'd1);
      chk({name, " armed tready"}, 64'(tready), 64'd0);

      start = 1'b1;
      cidx  = -1;
      cyc();
      start = 1'b0;

      for (int c = 0; c <= tdone + 2; c++) begin
         ne       = 0;
         exp_dout = idle;
         if (c > tdone) begin
            ne = nemit;
         end else begin
            for (int i = 0; i < nemit; i++) begin
               if (e[i] < c) begin
                  ne       = i + 1;
                  exp_dout = sd[i];
               end
            end
         end
         if (c >= 1) begin
            chk($sformatf("%s c%0d dout", name, c),     64'(dout),     64'(exp_dout));
            chk($sformatf("%s c%0d emitted", name, c),  64'(emitted),  64'(ne));
            chk($sformatf("%s c%0d done", name, c),     64'(done),     64'(c > tdone));
            chk($sformatf("%s c%0d running", name, c),  64'(running),  64'(c <= tdone));
            chk($sformatf("%s c%0d underrun", name, c), 64'(underrun),
                64'(iu >= 0 && c > due[iu]));
         end
         if (c == abort_at) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            chk({name, " abort dout"},     64'(dout),     64'(idle));
            chk({name, " abort ready"},    64'(ready),    64'd1);
            chk({name, " abort tready"},   64'(tready),   64'd0);
            chk({name, " abort done"},     64'(done),     64'd0);
            chk({name, " abort emitted"},  64'(emitted),  64'(ne));
            chk({name, " abort underrun"}, 64'(underrun), 64'(iu >= 0 && c > due[iu]));
            return;
         end
         if (c == rst_at) begin
            reset = 1'b1;
            cyc();
            chk_reset_vals({name, " midreset"});
            reset = 1'b0;
            drive_src();
            return;
         end
         arm = (c == 1);
         cyc();
         arm = 1'b0;
      end
      chk({name, " end accepted"}, 64'(n_acc),  64'(exp_acc));
      chk({name, " end tready"},   64'(tready), 64'd0);
      chk({name, " end ready"},    64'(ready),  64'd1);
   endtask

   initial begin
      int d, n, tl, gap;
      reset = 1'b1;
      arm = 1'b0; start = 1'b0; abort = 1'b0;
      ckdiv = '0; sample_count = '0; idle_level = '0;
      nb = 0; head = 0; cidx = -100; n_acc = 0;
      drive_src();
      repeat (3) cyc();
      reset = 1'b0;
      chk_reset_vals("reset");

      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("idle start ready",   64'(ready),   64'd1);
      chk("idle start running", 64'(running), 64'd0);
      chk("idle start armed",   64'(armed),   64'd0);

      mk_stream(4, -1, 0, 1'b0, 32'hA);
      play("t1", 0, 4, 4, 32'h5A5A_5A5A, -1, -1);

      mk_stream(3, 2, 0, 1'b0, 32'h100);
      play("t2", 2, 0, 3, 32'h0000_FFFF, -1, -1);

      mk_stream(3, -1, 0, 1'b0, 32'h200);
      sr[1] = 5;
      sr[2] = 5;
      play("t3", 1, 3, 3, 32'h1234_5678, -1, -1);

      mk_stream(8, -1, 0, 1'b0, 32'h300);
      play("t4a", 0, 8, 8, 32'hDEAD_BEEF, 2, -1);
      mk_stream(3, -1, 0, 1'b0, 32'h400);
      play("t4b", 0, 3, 3, 32'hCAFE_0000, -1, -1);

      mk_stream(5, -1, 0, 1'b0, 32'h500);
      play("t5", 1, 2, 2, 32'h0BAD_F00D, -1, -1);

      mk_stream(6, -1, 0, 1'b0, 32'h600);
      play("t6", 1, 6, 6, 32'h7777_7777, -1, 3);

      for (int r = 0; r < 8; r++) begin
         d   = int'($urandom_range(0, 3));
         n   = int'($urandom_range(1, 6));
         tl  = int'($urandom_range(0, 1));
         gap = ($urandom_range(0, 1) == 0) ? 0 : 4;
         mk_stream(n + 2, (tl != 0) ? n - 1 : -1, gap, 1'b1, 32'h0);
         play($sformatf("rnd%0d", r), d, (tl != 0) ? 0 : n, n, $urandom, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
`default_nettype wire
